// File: rtl/ins_exec_seq.sv
// Multi-cycle fetch/execute/memory/commit sequencer for the RV32I execute datapath.
// Owns pc, the retired-instruction count and the sticky fault state.
module ins_exec_seq #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned RETIRE_W    = 32
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                run,
   output logic                imem_req,
   output logic [31:0]         imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         ins,
   output logic                exec_op,
   input  logic                exec_done,
   input  logic                exec_mem_op,
   input  logic                exec_br_taken,
   input  logic [31:0]         exec_br_target,
   output logic                dmem_req,
   input  logic                dmem_ack,
   output logic                rf_we,
   output logic [31:0]         pc,
   output logic [RETIRE_W-1:0] retired,
   output logic                halted,
   output logic                fault
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_COMMIT = 3'd4;
   localparam logic [2:0] ST_FAULT  = 3'd5;

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [2:0]          state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         ins_q, ins_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                br_taken_q, br_taken_d;
   logic [31:0]         br_target_q, br_target_d;
   logic                exec_first_q, exec_first_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ins_d        = ins_q;
      retired_d    = retired_q;
      cnt_d        = cnt_q;
      br_taken_d   = br_taken_q;
      br_target_d  = br_target_q;
      exec_first_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            // Wait cycle k (1-based) sees cnt_q == k-1; ack on the last one still counts.
            if (imem_ack) begin
               ins_d        = imem_rdata;
               state_d      = ST_EXEC;
               exec_first_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               if (exec_br_taken && (exec_br_target[1:0] != 2'b00)) begin
                  state_d = ST_FAULT;
               end else begin
                  br_taken_d  = exec_br_taken;
                  br_target_d = exec_br_target;
                  cnt_d       = '0;
                  state_d     = exec_mem_op ? ST_MEM : ST_COMMIT;
               end
            end
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_d = ST_COMMIT;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_COMMIT: begin
            pc_d       = br_taken_q ? br_target_q : pc_q + 32'd4;
            retired_d  = retired_q + RETIRE_W'(1);
            br_taken_d = 1'b0;
            cnt_d      = '0;
            state_d    = run ? ST_FETCH : ST_IDLE;
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         ins_q        <= NOP;
         retired_q    <= '0;
         cnt_q        <= '0;
         br_taken_q   <= 1'b0;
         br_target_q  <= '0;
         exec_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ins_q        <= ins_d;
         retired_q    <= retired_d;
         cnt_q        <= cnt_d;
         br_taken_q   <= br_taken_d;
         br_target_q  <= br_target_d;
         exec_first_q <= exec_first_d;
      end
   end

   // Outputs decode straight from state so an async reset clears them in the same cycle.
   always_comb begin
      imem_req  = (state_q == ST_FETCH);
      imem_addr = pc_q;
      ins       = ins_q;
      exec_op   = (state_q == ST_EXEC) && exec_first_q;
      dmem_req  = (state_q == ST_MEM);
      rf_we     = (state_q == ST_COMMIT);
      pc        = pc_q;
      retired   = retired_q;
      halted    = (state_q == ST_IDLE);
      fault     = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_ins_exec_seq.sv
// Directed bench for ins_exec_seq: a per-cycle vector table plus hand-written
// sequences for memory timeout, last-cycle ack and reset during a data access.
module tb_ins_exec_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        exec_done = 1'b0;
   logic        exec_mem_op = 1'b0;
   logic        exec_br_taken = 1'b0;
   logic [31:0] exec_br_target = '0;
   logic        dmem_ack = 1'b0;

   logic        imem_req, exec_op, dmem_req, rf_we, halted, fault;
   logic [31:0] imem_addr, ins, pc, retired;

   int n_chk = 0;
   int n_err = 0;

   ins_exec_seq #(
      .RESET_PC   (32'h0000_0000),
      .MEM_TIMEOUT(16),
      .RETIRE_W   (32)
   ) dut (
      .sys_clk       (clk),
      .sys_rst_n     (rst_n),
      .run           (run),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .ins           (ins),
      .exec_op       (exec_op),
      .exec_done     (exec_done),
      .exec_mem_op   (exec_mem_op),
      .exec_br_taken (exec_br_taken),
      .exec_br_target(exec_br_target),
      .dmem_req      (dmem_req),
      .dmem_ack      (dmem_ack),
      .rf_we         (rf_we),
      .pc            (pc),
      .retired       (retired),
      .halted        (halted),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, ia, ed, mo, bt;
      logic [31:0] tg;
      logic        da;
      logic [5:0]  e_flags;  // {imem_req, exec_op, dmem_req, rf_we, halted, fault}
      logic [31:0] e_pc;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic ia, input logic ed, input logic mo,
                      input logic bt, input logic [31:0] tg, input logic da,
                      input logic [5:0] flags, input logic [31:0] epc, input logic [31:0] eret);
      vec_t v;
      v.r = r; v.ia = ia; v.ed = ed; v.mo = mo; v.bt = bt; v.tg = tg; v.da = da;
      v.e_flags = flags; v.e_pc = epc; v.e_ret = eret;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ia, input logic ed, input logic mo,
                        input logic bt, input logic [31:0] tg, input logic da);
      @(negedge clk);
      run = r; imem_ack = ia; exec_done = ed; exec_mem_op = mo;
      exec_br_taken = bt; exec_br_target = tg; dmem_ack = da;
   endtask

   function automatic logic [5:0] flags();
      return {imem_req, exec_op, dmem_req, rf_we, halted, fault};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0, 0);
      @(negedge clk);
      #1;
      chk("reset_flags", {58'd0, flags()}, {58'd0, 6'b000010});
      chk("reset_pc_ret", {pc, retired}, {32'h0, 32'h0});
      chk("reset_ins", {32'd0, ins}, {32'd0, 32'h0000_0013});
      rst_n = 1'b1;
   endtask

   localparam logic [5:0] F_IDLE  = 6'b000010;
   localparam logic [5:0] F_FETCH = 6'b100000;
   localparam logic [5:0] F_EXOP  = 6'b010000;
   localparam logic [5:0] F_EXEC  = 6'b000000;
   localparam logic [5:0] F_MEM   = 6'b001000;
   localparam logic [5:0] F_COMM  = 6'b000100;
   localparam logic [5:0] F_FAULT = 6'b000001;

   initial begin
      logic [31:0] exp_ins;

      // r ia ed mo bt target da | flags pc ret
      add(1, 0, 0, 0, 0, 32'h0,   0, F_IDLE,  32'h000, 0);   // 0
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h000, 0);
      add(1, 0, 1, 0, 0, 32'h0,   0, F_EXOP,  32'h000, 0);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h000, 0);
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h004, 1);
      add(1, 0, 1, 0, 0, 32'h0,   0, F_EXOP,  32'h004, 1);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h004, 1);
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h008, 2);
      add(1, 0, 1, 0, 0, 32'h0,   0, F_EXOP,  32'h008, 2);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h008, 2);
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h00C, 3);   // 10
      add(1, 0, 1, 0, 0, 32'h0,   0, F_EXOP,  32'h00C, 3);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h00C, 3);
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h010, 4);
      add(1, 0, 1, 0, 1, 32'h100, 0, F_EXOP,  32'h010, 4);   // aligned taken branch
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h010, 4);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h100, 5);   // fetch wait cycle
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h100, 5);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_EXOP,  32'h100, 5);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_EXEC,  32'h100, 5);   // strobe gone
      add(1, 0, 1, 1, 0, 32'h0,   0, F_EXEC,  32'h100, 5);   // 20 mem op
      add(1, 0, 0, 0, 0, 32'h0,   0, F_MEM,   32'h100, 5);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_MEM,   32'h100, 5);
      add(1, 0, 0, 0, 0, 32'h0,   1, F_MEM,   32'h100, 5);
      add(1, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h100, 5);
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h104, 6);
      add(0, 0, 1, 0, 0, 32'h0,   0, F_EXOP,  32'h104, 6);   // run dropped in EXEC
      add(0, 0, 0, 0, 0, 32'h0,   0, F_COMM,  32'h104, 6);
      add(0, 0, 0, 0, 0, 32'h0,   0, F_IDLE,  32'h108, 7);
      add(0, 1, 1, 0, 0, 32'h0,   1, F_IDLE,  32'h108, 7);   // stray acks ignored
      add(1, 0, 0, 0, 0, 32'h0,   0, F_IDLE,  32'h108, 7);   // 30
      add(1, 1, 0, 0, 0, 32'h0,   0, F_FETCH, 32'h108, 7);
      add(1, 0, 1, 0, 1, 32'h102, 0, F_EXOP,  32'h108, 7);   // misaligned target
      add(1, 0, 0, 0, 0, 32'h0,   0, F_FAULT, 32'h108, 7);
      add(1, 1, 1, 0, 0, 32'h0,   1, F_FAULT, 32'h108, 7);

      do_reset();
      exp_ins = 32'h0000_0013;
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].r, vq[i].ia, vq[i].ed, vq[i].mo, vq[i].bt, vq[i].tg, vq[i].da);
         imem_rdata = 32'hCAFE_0000 + 32'(i);
         #1;
         chk($sformatf("vec%0d_flags", i), {58'd0, flags()}, {58'd0, vq[i].e_flags});
         chk($sformatf("vec%0d_pc_addr", i), {pc, imem_addr}, {vq[i].e_pc, vq[i].e_pc});
         chk($sformatf("vec%0d_retired", i), {32'd0, retired}, {32'd0, vq[i].e_ret});
         chk($sformatf("vec%0d_ins", i), {32'd0, ins}, {32'd0, exp_ins});
         if (vq[i].e_flags[5] && vq[i].ia) exp_ins = 32'hCAFE_0000 + 32'(i);
      end

      // Fetch ack never arrives: 16 wait cycles with imem_req, then fault.
      do_reset();
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      for (int k = 1; k <= 16; k++) begin
         drive(1, 0, 0, 0, 0, 32'h0, 0);
         #1;
         chk($sformatf("to_wait%0d", k), {58'd0, flags()}, {58'd0, F_FETCH});
      end
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      #1;
      chk("to_fault", {58'd0, flags()}, {58'd0, F_FAULT});

      // Ack on the 16th wait cycle is still accepted.
      do_reset();
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      for (int k = 1; k <= 16; k++) drive(1, (k == 16), 0, 0, 0, 32'h0, 0);
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      #1;
      chk("late_ack_exec", {58'd0, flags()}, {58'd0, F_EXOP});

      // Reset asserted mid data access clears everything immediately.
      do_reset();
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      drive(1, 1, 0, 0, 0, 32'h0, 0);
      drive(1, 0, 1, 0, 0, 32'h0, 0);
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      drive(1, 1, 0, 0, 0, 32'h0, 0);
      drive(1, 0, 1, 1, 0, 32'h0, 0);
      drive(1, 0, 0, 0, 0, 32'h0, 0);
      #1;
      chk("pre_rst_mem", {58'd0, flags()}, {58'd0, F_MEM});
      chk("pre_rst_pc_ret", {pc, retired}, {32'h4, 32'h1});
      #1;
      rst_n = 1'b0;
      dmem_ack = 1'b1;
      #1;
      chk("rst_flags", {58'd0, flags()}, {58'd0, F_IDLE});
      chk("rst_pc_ret", {pc, retired}, {32'h0, 32'h0});
      chk("rst_ins", {32'd0, ins}, {32'd0, 32'h0000_0013});
      @(negedge clk);
      #1;
      chk("rst_hold_flags", {58'd0, flags()}, {58'd0, F_IDLE});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
